// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin two-port arbiter for the shared 256x8 SRAM
// Each access is a fixed ACC/RESP pair; locked bursts are capped at MAX_BURST grants.
`timescale 1ns/1ps
module sram_port_arbiter #(
  parameter int word_size = 8,
  parameter int addr_size = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_lock,
  input  logic                 m0_we,
  input  logic [addr_size-1:0] m0_addr,
  input  logic [word_size-1:0] m0_wdata,
  output logic                 m0_ack,
  output logic [word_size-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_lock,
  input  logic                 m1_we,
  input  logic [addr_size-1:0] m1_addr,
  input  logic [word_size-1:0] m1_wdata,
  output logic                 m1_ack,
  output logic [word_size-1:0] m1_rdata,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [addr_size-1:0] sram_addr,
  output logic [word_size-1:0] sram_wdata,
  input  logic [word_size-1:0] sram_rdata,
  output logic                 busy,
  output logic                 owner
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] burst_max = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t               state, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic [addr_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] wdata_q, wdata_d;
  logic [word_size-1:0] rdata0_q, rdata1_q;
  logic [BW-1:0]        burst_q, burst_d;
  logic                 sel;
  logic                 own_req, own_lock;
  logic                 resp_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      burst_q <= '0;
    end else begin
      state   <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      burst_q <= burst_d;
    end
  end

  // Read data is forwarded in RESP and also kept so it holds after the ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (resp_read) begin
      if (owner_q) rdata1_q <= sram_rdata;
      else         rdata0_q <= sram_rdata;
    end
  end

  always_comb begin
    state_d  = state;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    burst_d  = burst_q;
    own_req  = owner_q ? m1_req  : m0_req;
    own_lock = owner_q ? m1_lock : m0_lock;
    // In IDLE the port that did not go last wins a tie; in RESP only the owner can continue.
    if (state == IDLE) sel = (m0_req && m1_req) ? ~last_q : (m1_req && !m0_req);
    else               sel = owner_q;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = sel;
          we_d    = sel ? m1_we    : m0_we;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          burst_d = BW'(1);
          state_d = ACC;
        end
      end
      ACC: state_d = RESP;
      RESP: begin
        last_d = owner_q;
        if (own_req && own_lock && burst_q < burst_max) begin
          we_d    = sel ? m1_we    : m0_we;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          burst_d = burst_q + 1'b1;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_read  = (state == RESP) && !we_q;
  assign sram_en    = (state == ACC);
  assign sram_we    = (state == ACC) && we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = (state != IDLE);
  assign owner      = owner_q;
  assign m0_ack     = (state == RESP) && !owner_q;
  assign m1_ack     = (state == RESP) && owner_q;
  assign m0_rdata   = (resp_read && !owner_q) ? sram_rdata : rdata0_q;
  assign m1_rdata   = (resp_read && owner_q)  ? sram_rdata : rdata1_q;

endmodule
